ps2_key_decoder: RTL and testbench

Consumes the 16-bit `code_vector` and `ERR_CODE` outputs of the PS/2 receiver. Turns each new scancode into one key event:
- make/break and extended classification,
- Shift/Caps Lock modifier tracking,
- ASCII translation.

Events are buffered in a small FIFO and handed to downstream logic (display/UART) over a valid/ready handshake.

---
 rtl/ps2_pkg.sv | 47 ++++
 rtl/ps2_event_fifo.sv | 46 ++++
 rtl/ps2_key_decoder.sv | 126 ++++++++++++
 tb/tb_ps2_key_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared scancode constants, the key event record and the set-2 scancode to
// ASCII lookup used by the PS/2 key decoder.
package ps2_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic [7:0] ascii;
    } ps2_event_t;

    // Letters come back lowercase unless upper is set; unmapped codes give 0.
    function automatic logic [7:0] sc_to_ascii(input logic [7:0] code, input logic upper);
        logic [7:0] ch;
        ch = 8'h00;
        case (code)
            8'h1C: ch = 8'h61; 8'h32: ch = 8'h62; 8'h21: ch = 8'h63; 8'h23: ch = 8'h64;
            8'h24: ch = 8'h65; 8'h2B: ch = 8'h66; 8'h34: ch = 8'h67; 8'h33: ch = 8'h68;
            8'h43: ch = 8'h69; 8'h3B: ch = 8'h6A; 8'h42: ch = 8'h6B; 8'h4B: ch = 8'h6C;
            8'h3A: ch = 8'h6D; 8'h31: ch = 8'h6E; 8'h44: ch = 8'h6F; 8'h4D: ch = 8'h70;
            8'h15: ch = 8'h71; 8'h2D: ch = 8'h72; 8'h1B: ch = 8'h73; 8'h2C: ch = 8'h74;
            8'h3C: ch = 8'h75; 8'h2A: ch = 8'h76; 8'h1D: ch = 8'h77; 8'h22: ch = 8'h78;
            8'h35: ch = 8'h79; 8'h1A: ch = 8'h7A;
            8'h45: ch = 8'h30; 8'h16: ch = 8'h31; 8'h1E: ch = 8'h32; 8'h26: ch = 8'h33;
            8'h25: ch = 8'h34; 8'h2E: ch = 8'h35; 8'h36: ch = 8'h36; 8'h3D: ch = 8'h37;
            8'h3E: ch = 8'h38; 8'h46: ch = 8'h39;
            SC_SPACE: ch = 8'h20;
            SC_ENTER: ch = 8'h0D;
            SC_BKSP:  ch = 8'h08;
            default:  ch = 8'h00;
        endcase
        if (upper && ch >= 8'h61 && ch <= 8'h7A) begin
            ch = ch - 8'h20;
        end
        return ch;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO with full/empty flags; a push on a full FIFO is accepted
// only when a pop happens on the same edge.
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             CLOCK,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indexes match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 receiver code_vector changes into make/break key events with
// Shift/Caps tracking and ASCII, buffered in a small event FIFO.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLOCK,
    input  logic        rst,
    input  logic [15:0] code_vector,
    input  logic [1:0]  ERR_CODE,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [7:0]  ev_code,
    output logic        ev_ext,
    output logic        ev_break,
    output logic [7:0]  ev_ascii,
    output logic        shift_active,
    output logic        caps_lock,
    output logic        overflow,
    output logic [7:0]  err_count
);
    import ps2_pkg::*;

    logic [15:0] prev_cv;
    logic        ext_pend, ext_pend_nxt;
    logic        lshift_held, rshift_held;
    logic        lshift_nxt, rshift_nxt, caps_nxt;
    logic        change, rx_err;
    logic        cls_valid, cls_ext, cls_brk;
    logic [7:0]  lo, hi;
    ps2_event_t  push_ev, head_ev;
    logic        fifo_full, fifo_empty;

    assign lo     = code_vector[7:0];
    assign hi     = code_vector[15:8];
    assign change = (code_vector != prev_cv);
    assign rx_err = |ERR_CODE;

    always_comb begin
        cls_valid    = 1'b0;
        cls_ext      = 1'b0;
        cls_brk      = 1'b0;
        ext_pend_nxt = ext_pend;
        if (rx_err) begin
            ext_pend_nxt = 1'b0;
        end else if (change) begin
            // A lone prefix byte only arms the extended flag for the next key.
            if (lo == SC_E0 || lo == SC_F0) begin
                if (code_vector == 16'h00E0 || code_vector == 16'hE0F0) ext_pend_nxt = 1'b1;
            end else if (hi == SC_F0) begin
                cls_valid    = 1'b1;
                cls_brk      = 1'b1;
                cls_ext      = ext_pend;
                ext_pend_nxt = 1'b0;
            end else if (hi == SC_E0) begin
                cls_valid    = 1'b1;
                cls_ext      = 1'b1;
                ext_pend_nxt = 1'b0;
            end else if (hi == 8'h00) begin
                cls_valid    = 1'b1;
                ext_pend_nxt = 1'b0;
            end else begin
                ext_pend_nxt = 1'b0;
            end
        end
    end

    always_comb begin
        lshift_nxt = lshift_held;
        rshift_nxt = rshift_held;
        caps_nxt   = caps_lock;
        if (cls_valid && !cls_ext) begin
            if (lo == SC_LSHIFT) lshift_nxt = !cls_brk;
            if (lo == SC_RSHIFT) rshift_nxt = !cls_brk;
            if (lo == SC_CAPS && !cls_brk) caps_nxt = !caps_lock;
        end
        push_ev.ext   = cls_ext;
        push_ev.brk   = cls_brk;
        push_ev.code  = lo;
        push_ev.ascii = (cls_brk || cls_ext) ? 8'h00
                        : sc_to_ascii(lo, (lshift_nxt | rshift_nxt) ^ caps_nxt);
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            prev_cv     <= 16'h0000;
            ext_pend    <= 1'b0;
            lshift_held <= 1'b0;
            rshift_held <= 1'b0;
            caps_lock   <= 1'b0;
            overflow    <= 1'b0;
            err_count   <= 8'h00;
        end else begin
            prev_cv     <= code_vector;
            ext_pend    <= ext_pend_nxt;
            lshift_held <= lshift_nxt;
            rshift_held <= rshift_nxt;
            caps_lock   <= caps_nxt;
            if (cls_valid && fifo_full && !ev_ready) overflow <= 1'b1;
            if (rx_err && err_count != 8'hFF) err_count <= err_count + 8'h01;
        end
    end

    // Handshake: ev_valid means the head is a real event and ev_* hold it
    // steady; the head is consumed on any edge where ev_valid && ev_ready.
    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ps2_event_t))
    ) u_fifo (
        .CLOCK     (CLOCK),
        .rst       (rst),
        .push      (cls_valid),
        .push_data (push_ev),
        .pop       (ev_ready),
        .pop_data  (head_ev),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ev_valid     = !fifo_empty;
    assign ev_code      = fifo_empty ? 8'h00 : head_ev.code;
    assign ev_ext       = !fifo_empty && head_ev.ext;
    assign ev_break     = !fifo_empty && head_ev.brk;
    assign ev_ascii     = fifo_empty ? 8'h00 : head_ev.ascii;
    assign shift_active = lshift_held | rshift_held;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scancode sequences, an event-queue
// reference model compared every cycle, plus literal spot checks.
module tb_ps2_key_decoder;

    localparam int DEPTH = 4;

    logic        CLOCK = 1'b0;
    logic        rst;
    logic [15:0] code_vector;
    logic [1:0]  ERR_CODE;
    logic        ev_valid;
    logic        ev_ready;
    logic [7:0]  ev_code;
    logic        ev_ext;
    logic        ev_break;
    logic [7:0]  ev_ascii;
    logic        shift_active;
    logic        caps_lock;
    logic        overflow;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .CLOCK        (CLOCK),
        .rst          (rst),
        .code_vector  (code_vector),
        .ERR_CODE     (ERR_CODE),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_code      (ev_code),
        .ev_ext       (ev_ext),
        .ev_break     (ev_break),
        .ev_ascii     (ev_ascii),
        .shift_active (shift_active),
        .caps_lock    (caps_lock),
        .overflow     (overflow),
        .err_count    (err_count)
    );

    // ---------------- clock ----------------
    always #5 CLOCK = ~CLOCK;

    // ---------------- reference model ----------------
    logic [17:0] exp_q[$];
    logic [15:0] m_prev = '0;
    logic        m_ext_pend = 1'b0;
    logic        m_lsh = 1'b0, m_rsh = 1'b0, m_caps = 1'b0, m_ovf = 1'b0;
    logic [7:0]  m_err = '0;
    bit          model_live = 1'b0;

    logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                   8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                   8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                   8'h35, 8'h1A};
    logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                  8'h3E, 8'h46};

    function automatic logic [7:0] model_ascii(input logic [7:0] code, input logic upper);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 26; i++)
            if (letter_sc[i] == code) r = (upper ? 8'd65 : 8'd97) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (digit_sc[i] == code) r = 8'd48 + 8'(i);
        if (code == 8'h29) r = 8'h20;
        if (code == 8'h5A) r = 8'h0D;
        if (code == 8'h66) r = 8'h08;
        return r;
    endfunction

    task automatic model_step();
        logic       have, ext, brk;
        logic [7:0] lo, hi, asc;
        have = 1'b0; ext = 1'b0; brk = 1'b0;
        lo = code_vector[7:0];
        hi = code_vector[15:8];
        if (rst) begin
            exp_q.delete();
            m_prev = '0; m_ext_pend = 1'b0; m_lsh = 1'b0; m_rsh = 1'b0;
            m_caps = 1'b0; m_ovf = 1'b0; m_err = '0;
        end else begin
            if (exp_q.size() != 0 && ev_ready) void'(exp_q.pop_front());
            if (ERR_CODE != 2'b00) begin
                m_ext_pend = 1'b0;
                if (m_err != 8'hFF) m_err = m_err + 8'h01;
            end else if (code_vector != m_prev) begin
                if (lo == 8'hE0 || lo == 8'hF0) begin
                    if (code_vector == 16'h00E0 || code_vector == 16'hE0F0) m_ext_pend = 1'b1;
                end else begin
                    case (hi)
                        8'hF0: begin have = 1'b1; brk = 1'b1; ext = m_ext_pend; end
                        8'hE0: begin have = 1'b1; ext = 1'b1; end
                        8'h00: have = 1'b1;
                        default: ;
                    endcase
                    m_ext_pend = 1'b0;
                end
            end
            if (have) begin
                if (!ext && lo == 8'h12) m_lsh = !brk;
                if (!ext && lo == 8'h59) m_rsh = !brk;
                if (!ext && !brk && lo == 8'h58) m_caps = !m_caps;
                asc = (brk || ext) ? 8'h00 : model_ascii(lo, (m_lsh | m_rsh) ^ m_caps);
                if (exp_q.size() < DEPTH) exp_q.push_back({ext, brk, lo, asc});
                else m_ovf = 1'b1;
            end
            m_prev = code_vector;
        end
        model_live = 1'b1;
    endtask

    initial forever begin
        @(posedge CLOCK);
        model_step();
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge CLOCK);
        if (model_live) begin
            chk("m_valid", 32'(ev_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0)
                chk("m_event", 32'({ev_ext, ev_break, ev_code, ev_ascii}), 32'(exp_q[0]));
            chk("m_shift", 32'(shift_active), 32'(m_lsh | m_rsh));
            chk("m_caps", 32'(caps_lock), 32'(m_caps));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            chk("m_err_count", 32'(err_count), 32'(m_err));
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic [15:0] cv, input logic [1:0] e);
        code_vector = cv;
        ERR_CODE    = e;
        @(posedge CLOCK);
        #1;
    endtask

    logic [15:0] seq [14] = '{16'h0059, 16'h0016, 16'h001A, 16'h00F0, 16'hF059, 16'h0045,
                              16'h0029, 16'h005A, 16'h0066, 16'h00E0, 16'hE012, 16'h0015,
                              16'h0058, 16'h001B};

    initial begin
        rst = 1'b1; code_vector = '0; ERR_CODE = '0; ev_ready = 1'b1;
        step(16'h0000, 2'b00);
        step(16'h0000, 2'b00);
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_code", 32'(ev_code), 0);
        chk("rst_mods", 32'({shift_active, caps_lock, overflow}), 0);
        chk("rst_err", 32'(err_count), 0);
        rst = 1'b0;
        step(16'h0000, 2'b00);
        chk("idle_valid", 32'(ev_valid), 0);

        // single make
        step(16'h001C, 2'b00);
        chk("a_valid", 32'(ev_valid), 1);
        chk("a_event", 32'({ev_ext, ev_break, ev_code}), 32'h01C);
        chk("a_ascii", 32'(ev_ascii), 32'h61);

        // shift / caps
        step(16'h0012, 2'b00);
        chk("lsh_code", 32'(ev_code), 32'h12);
        chk("lsh_ascii", 32'(ev_ascii), 0);
        chk("lsh_shift", 32'(shift_active), 1);
        step(16'h00F0, 2'b00);
        chk("f0_none", 32'(ev_valid), 0);
        step(16'hF012, 2'b00);
        chk("lsh_brk", 32'({ev_break, ev_code}), 32'h112);
        chk("lsh_rel", 32'(shift_active), 0);
        step(16'h0058, 2'b00);
        chk("caps_code", 32'(ev_code), 32'h58);
        chk("caps_on", 32'(caps_lock), 1);
        step(16'h001C, 2'b00);
        chk("A_ascii", 32'(ev_ascii), 32'h41);

        // extended
        step(16'h00E0, 2'b00);
        chk("e0_none", 32'(ev_valid), 0);
        step(16'hE075, 2'b00);
        chk("ext_make", 32'({ev_ext, ev_break, ev_code}), 32'h275);
        step(16'h00E0, 2'b00);
        chk("e0_none2", 32'(ev_valid), 0);
        step(16'hE0F0, 2'b00);
        chk("e0f0_none", 32'(ev_valid), 0);
        step(16'hF075, 2'b00);
        chk("ext_brk", 32'({ev_ext, ev_break, ev_code}), 32'h375);
        step(16'hF075, 2'b00);
        chk("ext_done", 32'(ev_valid), 0);

        // overflow and drain
        ev_ready = 1'b0;
        step(16'h0015, 2'b00);
        step(16'h001D, 2'b00);
        step(16'h0024, 2'b00);
        step(16'h002D, 2'b00);
        chk("full_no_ovf", 32'(overflow), 0);
        step(16'h002C, 2'b00);
        chk("ovf_set", 32'(overflow), 1);
        chk("head_15", 32'(ev_code), 32'h15);
        ev_ready = 1'b1;
        step(16'h002C, 2'b00);
        chk("head_1D", 32'(ev_code), 32'h1D);
        step(16'h002C, 2'b00);
        chk("head_24", 32'(ev_code), 32'h24);
        step(16'h002C, 2'b00);
        chk("head_2D", 32'(ev_code), 32'h2D);
        step(16'h002C, 2'b00);
        chk("drained", 32'(ev_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // mid-run reset, then receiver error
        rst = 1'b1;
        step(16'h0000, 2'b00);
        chk("rst2_state", 32'({ev_valid, shift_active, caps_lock, overflow}), 0);
        rst = 1'b0;
        step(16'h0000, 2'b00);
        step(16'h001C, 2'b01);
        chk("err_drop", 32'(ev_valid), 0);
        chk("err_cnt1", 32'(err_count), 1);
        step(16'h001C, 2'b00);
        chk("err_nochg", 32'(ev_valid), 0);
        step(16'h0032, 2'b00);
        chk("b_event", 32'({ev_ext, ev_break, ev_code}), 32'h032);
        chk("b_ascii", 32'(ev_ascii), 32'h62);

        // mixed table with back-pressure, checked by the model
        for (int i = 0; i < 14; i++) begin
            ev_ready = ((i % 3) != 0);
            step(seq[i], 2'b00);
        end
        ev_ready = 1'b1;
        repeat (6) step(16'h001B, 2'b00);
        chk("tbl_drained", 32'(ev_valid), 0);

        // error counter saturation
        repeat (300) step(16'h001B, 2'b10);
        chk("err_sat", 32'(err_count), 32'hFF);
        step(16'h001B, 2'b00);
        repeat (2) @(negedge CLOCK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
